// File: rtl/rojobot_pkg.sv
// Shared definitions for the RoJoBot update-capture stage: control bit
// indices, status word layout, snapshot byte lanes and the snapshot type.
package rojobot_pkg;

  // Control word bits coming from the register block's o_reg_a
  localparam int CTL_POP    = 0;
  localparam int CTL_OVFCLR = 1;
  localparam int CTL_FLUSH  = 2;

  // Status word layout presented on i_reg_b
  localparam int STAT_SEQ_LSB = 0;
  localparam int STAT_SEQ_W   = 8;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 5;
  localparam int STAT_VALID   = 13;
  localparam int STAT_OVF     = 14;
  localparam int STAT_TS_LSB  = 16;
  localparam int STAT_TS_W    = 16;

  // Snapshot byte lanes presented on i_reg_a
  localparam int SNAP_LOCX_LSB = 0;
  localparam int SNAP_LOCY_LSB = 8;
  localparam int SNAP_SENS_LSB = 16;
  localparam int SNAP_INFO_LSB = 24;

  // Width of the optional free-running timestamp
  localparam int TS_W = 16;

  // Packed so that the struct bit layout matches the snapshot word lanes
  typedef struct packed {
    logic [7:0] info;
    logic [7:0] sens;
    logic [7:0] locy;
    logic [7:0] locx;
  } snap_t;

  // Assemble the status word from its fields; bit 15 is always zero
  function automatic logic [31:0] pack_stat(
    input logic [STAT_SEQ_W-1:0] seq,
    input logic [STAT_CNT_W-1:0] cnt,
    input logic                  valid,
    input logic                  ovf,
    input logic [STAT_TS_W-1:0]  ts
  );
    return {ts, 1'b0, ovf, valid, cnt, seq};
  endfunction

endpackage

// File: rtl/rojobot_upd_fifo.sv
// Generic single-clock FIFO with synchronous flush. The head entry is read
// combinationally; the consumer registers it. Push while full is accepted
// only together with a pop; pop while empty is ignored.
module rojobot_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_acc;
  logic             pop_acc;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Qualify requests: flush overrides both, pop needs data, push needs room
  always_comb begin
    pop_acc  = pop_i & ~flush_i & ~empty_o;
    push_acc = push_i & ~flush_i & (~full_o | pop_acc);
  end

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy guards reads
  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/rojobot_upd_capture.sv
// Capture stage between the RoJoBot IP and the rojobot_top register block.
// Each rising edge of bot_upd_i snapshots the bot outputs into a small FIFO;
// software drains it with toggle bits so no update is lost between polls.
// Optional build macro ROJOBOT_UPD_TIMESTAMP_EN adds a 16-bit cycle
// timestamp to each entry, reported in stat_o[31:16] (zero otherwise).
module rojobot_upd_capture
  import rojobot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  bot_locx_i,
  input  logic [7:0]  bot_locy_i,
  input  logic [7:0]  bot_sens_i,
  input  logic [7:0]  bot_info_i,
  input  logic        bot_upd_i,
  input  logic [31:0] ctl_i,
  output logic [31:0] snap_o,
  output logic [31:0] stat_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
`ifdef ROJOBOT_UPD_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
    logic [SEQ_W-1:0] seq;
    snap_t            snap;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic             upd_q;
  logic [1:0]       ctl_q;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      snap_q, snap_d;
  logic [31:0]      stat_q, stat_d;

  logic             push_req, pop_req, clr_req, flush;
  logic             pop_ok, push_ok, drop;
  entry_t           new_entry;
  entry_t           head;
  logic [ENTRY_W-1:0] head_bits;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic [TS_W-1:0]  head_ts;
  logic             unused_ctl;

  assign unused_ctl = ^ctl_i[31:CTL_FLUSH+1];

`ifdef ROJOBOT_UPD_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running cycle counter stamped into each entry at push
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) ts_q <= '0;
    else          ts_q <= ts_q + TS_W'(1);
  end

  assign new_entry.ts = ts_q;
  assign head_ts      = head.ts;
`else
  assign head_ts = '0;
`endif

  assign new_entry.seq       = seq_q;
  assign new_entry.snap.info = bot_info_i;
  assign new_entry.snap.sens = bot_sens_i;
  assign new_entry.snap.locy = bot_locy_i;
  assign new_entry.snap.locx = bot_locx_i;
  assign head                = entry_t'(head_bits);

  // Decode edge/toggle requests and arbitrate push, pop and overflow
  always_comb begin
    push_req = bot_upd_i & ~upd_q;
    pop_req  = ctl_i[CTL_POP] ^ ctl_q[0];
    clr_req  = ctl_i[CTL_OVFCLR] ^ ctl_q[1];
    flush    = ctl_i[CTL_FLUSH];
    pop_ok   = pop_req & ~flush & ~fifo_empty;
    push_ok  = push_req & ~flush & (~fifo_full | pop_ok);
    drop     = push_req & ~flush & fifo_full & ~pop_ok;
    seq_d    = push_ok ? seq_q + SEQ_W'(1) : seq_q;
    ovf_d    = ovf_q;
    if (clr_req) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;   // a drop in the same cycle beats the clear
  end

  // Output words reflect the FIFO state as it stands before this edge
  always_comb begin
    snap_d = '0;
    stat_d = pack_stat(8'd0, 5'd0, 1'b0, ovf_q, 16'd0);
    if (!fifo_empty) begin
      snap_d = head.snap;
      stat_d = pack_stat(STAT_SEQ_W'(head.seq), STAT_CNT_W'(fifo_count),
                         1'b1, ovf_q, head_ts);
    end
  end

  // Edge/toggle history, sequence counter, overflow flag and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      upd_q  <= 1'b0;
      ctl_q  <= '0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
      snap_q <= '0;
      stat_q <= '0;
    end else begin
      upd_q  <= bot_upd_i;
      ctl_q  <= {ctl_i[CTL_OVFCLR], ctl_i[CTL_POP]};
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
      snap_q <= snap_d;
      stat_q <= stat_d;
    end
  end

  assign snap_o = snap_q;
  assign stat_o = stat_q;

  rojobot_upd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push_ok),
    .pop_i   (pop_ok),
    .flush_i (flush),
    .din_i   (new_entry),
    .head_o  (head_bits),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_rojobot_upd_capture.sv
// Bench for rojobot_upd_capture: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_rojobot_upd_capture;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  locx, locy, sens, info;
  logic        upd;
  logic [31:0] ctl;
  logic [31:0] snap_o, stat_o;

  always #5 clk = ~clk;

  rojobot_upd_capture #(.DEPTH(DEPTH), .SEQ_W(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .bot_locx_i (locx),
    .bot_locy_i (locy),
    .bot_sens_i (sens),
    .bot_info_i (info),
    .bot_upd_i  (upd),
    .ctl_i      (ctl),
    .snap_o     (snap_o),
    .stat_o     (stat_o)
  );

  typedef struct {
    logic [31:0] snap;
    logic [7:0]  seq;
    logic [15:0] ts;
  } ment_t;

  ment_t       mq[$];
  logic [7:0]  m_seq;
  logic        m_ovf;
  logic        m_prev_upd;
  logic [1:0]  m_ctl;
  logic [15:0] m_cyc;
  logic [31:0] exp_snap = '0;
  logic [31:0] exp_stat = '0;
  bit          started = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, want, $time);
    end else begin
      $display("ok   %s: %08h", name, got);
    end
  endtask

  // One clock of the reference model, evaluated from the inputs at the edge
  task automatic model_step();
    bit push, pop, clr, drop;
    ment_t e;
    if (rst) begin
      mq.delete();
      m_seq = 0; m_ovf = 0; m_prev_upd = 0; m_ctl = 0; m_cyc = 0;
      exp_snap = 0; exp_stat = 0;
    end else begin
      if (mq.size() > 0) begin
        exp_snap = mq[0].snap;
`ifdef ROJOBOT_UPD_TIMESTAMP_EN
        exp_stat = {mq[0].ts, 1'b0, m_ovf, 1'b1, 5'(mq.size()), mq[0].seq};
`else
        exp_stat = {16'h0, 1'b0, m_ovf, 1'b1, 5'(mq.size()), mq[0].seq};
`endif
      end else begin
        exp_snap = 0;
        exp_stat = {16'h0, 1'b0, m_ovf, 1'b0, 5'd0, 8'd0};
      end
      push = upd && !m_prev_upd;
      pop  = ctl[0] != m_ctl[0];
      clr  = ctl[1] != m_ctl[1];
      drop = 0;
      if (ctl[2]) begin
        mq.delete();
      end else begin
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (push) begin
          if (mq.size() < DEPTH) begin
            e.snap = {info, sens, locy, locx};
            e.seq  = m_seq;
            e.ts   = m_cyc;
            mq.push_back(e);
            m_seq = m_seq + 8'd1;
          end else begin
            drop = 1;
          end
        end
      end
      if (clr)  m_ovf = 0;
      if (drop) m_ovf = 1;
      m_prev_upd = upd;
      m_ctl = ctl[1:0];
      m_cyc = m_cyc + 16'd1;
    end
    started = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare DUT against model away from the active edge
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("model_snap", snap_o, exp_snap);
      check("model_stat", stat_o, exp_stat);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; upd = 0; ctl = 0;
    tick(2);
    rst = 0;
  endtask

  task automatic push(input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] s, input logic [7:0] i);
    locx = x; locy = y; sens = s; info = i;
    upd = 1; tick(1);
    upd = 0; tick(1);
  endtask

  task automatic pop();
    ctl[0] = ~ctl[0]; tick(2);
  endtask

  task automatic ovf_clear();
    ctl[1] = ~ctl[1]; tick(2);
  endtask

  initial begin
    logic [31:0] v;
    locx = 0; locy = 0; sens = 0; info = 0; upd = 0; ctl = 0; rst = 1;
    tick(1);
    check("reset_snap", snap_o, 32'h0);
    check("reset_stat", stat_o, 32'h0);
    do_reset();

    // 1: single pulse
    push(8'h12, 8'h34, 8'h56, 8'h78);
    check("t1_snap", snap_o, 32'h78563412);
    check("t1_stat_lo", {16'h0, stat_o[15:0]}, 32'h0000_2100);

    // 2: level held high -> one push only
    locx = 8'hA1; locy = 8'hA2; sens = 8'hA3; info = 8'hA4;
    upd = 1; tick(10); upd = 0; tick(1);
    check("t2_count", {27'h0, stat_o[12:8]}, 32'd2);
    pop(); pop();
    check("t2_empty_stat", {18'h0, stat_o[13:0]}, 32'h0);
    check("t2_empty_snap", snap_o, 32'h0);

    // 3: overfill depth 4, drain in order, extra pop ignored
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(i), 8'(i + 16), 8'h5A, 8'hC3);
    check("t3_full_ovf", {25'h0, stat_o[14:8]}, 32'h64);
    for (int i = 0; i < 4; i++) begin
      check("t3_head_seq", {24'h0, stat_o[7:0]}, 32'(i));
      v = {8'hC3, 8'h5A, 8'(i + 16), 8'(i)};
      check("t3_head_snap", snap_o, v);
      pop();
    end
    pop();
    check("t3_underflow_stat", {18'h0, stat_o[13:0]}, 32'h0);
    check("t3_underflow_snap", snap_o, 32'h0);
    ovf_clear();
    check("t3_ovf_cleared", {31'h0, stat_o[14]}, 32'h0);

    // 4: push and pop together while full
    do_reset();
    for (int i = 0; i < 4; i++) push(8'(i), 8'h11, 8'h22, 8'h33);
    locx = 8'h44; upd = 1; ctl[0] = ~ctl[0]; tick(1);
    upd = 0; tick(1);
    check("t4_full_no_ovf", {25'h0, stat_o[14:8]}, 32'h24);
    check("t4_head_seq", {24'h0, stat_o[7:0]}, 32'd1);
    pop(); pop(); pop();
    check("t4_tail_seq", {24'h0, stat_o[7:0]}, 32'd4);
    check("t4_tail_snap", snap_o, 32'h33221144);

    // 5: overflow set wins over a same-cycle clear
    for (int i = 0; i < 3; i++) push(8'(i + 5), 8'h01, 8'h02, 8'h03);
    locx = 8'hEE; upd = 1; ctl[1] = ~ctl[1]; tick(1);
    upd = 0; tick(1);
    check("t5_set_wins", {31'h0, stat_o[14]}, 32'h1);
    check("t5_count", {27'h0, stat_o[12:8]}, 32'd4);
    ovf_clear();
    check("t5_clear_alone", {31'h0, stat_o[14]}, 32'h0);

    // 6: flush with 3 entries, pushes and a toggle during flush
    pop();
    check("t6_pre_count", {27'h0, stat_o[12:8]}, 32'd3);
    ctl[2] = 1; tick(1);
    push(8'hF0, 8'hF1, 8'hF2, 8'hF3);
    ctl[0] = ~ctl[0];
    push(8'hF4, 8'hF5, 8'hF6, 8'hF7);
    check("t6_flushed", {18'h0, stat_o[14:0]} & 32'h7F00, 32'h0);
    ctl[2] = 0; tick(1);
    push(8'h9A, 8'h9B, 8'h9C, 8'h9D);
    check("t6_seq_continue", {24'h0, stat_o[7:0]}, 32'd8);
    check("t6_count", {27'h0, stat_o[12:8]}, 32'd1);
    check("t6_snap", snap_o, 32'h9D9C9B9A);

    // reset mid-operation discards the entry
    rst = 1; tick(1);
    check("mid_reset_snap", snap_o, 32'h0);
    check("mid_reset_stat", stat_o, 32'h0);
    rst = 0; tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
